// File: rtl/mesh_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mesh_arb_pkg
// Description : Shared state encoding and sizing helper for the mesh
//               injection arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mesh_arb_pkg;

  // Arbiter states: IDLE (hold register empty) and OFFER (packet on mesh port)
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Index width for n requesters, never narrower than one bit
  function automatic int id_w(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage : mesh_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of eligible at or above ptr, wrapping around to bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import mesh_arb_pkg::*;
#(
  parameter int num_req = 4
) (
  input  logic [num_req-1:0]          eligible,
  input  logic [id_w(num_req)-1:0]    ptr,
  output logic                        any,
  output logic [id_w(num_req)-1:0]    winner
);

  localparam int ID_W = id_w(num_req);

  assign any = |eligible;

  // Scan offsets from farthest to nearest so the closest one to ptr wins last
  always_comb begin
    int w_idx;
    w_idx  = 0;
    winner = '0;
    for (int k = num_req - 1; k >= 0; k--) begin
      w_idx = (int'(ptr) + k) % num_req;
      if (eligible[w_idx]) begin
        winner = ID_W'(w_idx);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mesh_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mesh_inject_arbiter
// Description : Shares one mesh terminal injection port among num_req local
//               requester FIFOs using masked round-robin and a one-entry hold
//               register. Supports one injected packet per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_inject_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int pckg_sz = 40,
  parameter int num_req = 4,
  parameter int cnt_w   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [num_req-1:0]          req_pndng,
  input  logic [num_req*pckg_sz-1:0]  req_data,
  input  logic [num_req-1:0]          req_mask,
  output logic [num_req-1:0]          req_pop,
  output logic                        mesh_pndng,
  output logic [pckg_sz-1:0]          mesh_data,
  input  logic                        mesh_popin,
  output logic [id_w(num_req)-1:0]    grant_id,
  output logic [cnt_w-1:0]            pkt_cnt
);

  localparam int ID_W = id_w(num_req);

  state_t              r_state;
  logic [pckg_sz-1:0]  r_hold;
  logic [ID_W-1:0]     r_grant;
  logic [ID_W-1:0]     r_ptr;
  logic [cnt_w-1:0]    r_cnt;

  logic [num_req-1:0]  w_eligible;
  logic                w_any;
  logic [ID_W-1:0]     w_winner;
  logic                w_accept;
  logic                w_load_ok;
  logic                w_take;
  logic [ID_W-1:0]     w_ptr_nxt;

  assign w_eligible = req_pndng & req_mask;
  assign w_accept   = (r_state == OFFER) && mesh_popin;
  assign w_load_ok  = (r_state == IDLE) || w_accept;
  // No head is consumed while reset is held, whatever the state register shows
  assign w_take     = reset && w_load_ok && w_any;
  assign w_ptr_nxt  = (w_winner == ID_W'(num_req - 1)) ? '0 : (w_winner + 1'b1);

  rr_pick #(
    .num_req (num_req)
  ) u_rr_pick (
    .eligible (w_eligible),
    .ptr      (r_ptr),
    .any      (w_any),
    .winner   (w_winner)
  );

  // One-hot pop of the winning head in the same cycle the hold register loads
  always_comb begin
    req_pop = '0;
    if (w_take) begin
      req_pop[w_winner] = 1'b1;
    end
  end

  // FSM, hold register, round-robin pointer and accepted-packet counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load_ok) begin
        if (w_any) begin
          r_hold  <= req_data[int'(w_winner)*pckg_sz +: pckg_sz];
          r_grant <= w_winner;
          r_ptr   <= w_ptr_nxt;
          r_state <= OFFER;
        end else begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign mesh_pndng = (r_state == OFFER);
  assign mesh_data  = r_hold;
  assign grant_id   = r_grant;
  assign pkt_cnt    = r_cnt;

endmodule : mesh_inject_arbiter
`default_nettype wire

// File: doc/mesh_inject_arbiter.md
Name: mesh_inject_arbiter

Overview:
- Shares one mesh terminal injection port (pndng_i_in / data_out_i_in / popin of one terminal) among num_req local requester FIFOs.
- Each cycle it is free, it picks a requester by masked round-robin, pops that requester's head into a one-entry hold register, and offers it to the mesh until the mesh pops it.
- Sits between local traffic sources and one mesh terminal; back-to-back injection is supported at one packet per cycle.

Parameters:
- pckg_sz, 40, packet width in bits (whole mesh packet, one flit).
- num_req, 4, number of requesters; minimum 2.
- cnt_w, 16, width of the forwarded-packet counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- req_pndng  in  num_req  requester i has a packet at its FIFO head.
- req_data  in  num_req*pckg_sz  head packets; requester i occupies bits [i*pckg_sz +: pckg_sz].
- req_mask  in  num_req  1 = requester eligible for a grant.
- req_pop  out  num_req  one-hot pop; combinational; pulse marks consumption of head i at the next edge.
- mesh_pndng  out  1  hold register valid; drives the terminal's pndng_i_in.
- mesh_data  out  pckg_sz  hold register contents; drives data_out_i_in.
- mesh_popin  in  1  mesh takes mesh_data this cycle.
- grant_id  out  ID_W  index of the requester whose packet is held.
- pkt_cnt  out  cnt_w  packets accepted by the mesh since reset; wraps modulo 2^cnt_w.

Behaviour:
- Reset (reset==0 at an edge) forces the following:
  - state IDLE; mesh_pndng=0; mesh_data=0; grant_id=0; pkt_cnt=0; RR pointer=0.
  - req_pop=0 during any cycle in which reset==0.
  - Reset mid-OFFER discards the held packet. It is not re-offered and pkt_cnt does not count it.
- Round-robin pick:
  - eligible = req_pndng & req_mask.
  - Winner is the first set bit of eligible, searching from the RR pointer upward with wrap-around: ptr, ptr+1 … num_req-1, 0 … ptr-1.
- load_ok = (state==IDLE) or (state==OFFER and mesh_popin==1).
- When load_ok and eligible is nonzero, in the same cycle:
  - req_pop[winner]=1.
  - Next edge: hold ← req_data[winner]; grant_id ← winner; pointer ← (winner+1) mod num_req; state OFFER.
- When load_ok and eligible is zero:
  - req_pop=0.
  - If the cycle was in OFFER with mesh_popin, the next state is IDLE and mesh_pndng falls.
- OFFER state:
  - mesh_pndng=1; mesh_data and grant_id are stable until mesh_popin.
  - Without popin, the state holds indefinitely. No timeout; requesters stay un-popped.
- pkt_cnt increments by 1 on every edge where state==OFFER and mesh_popin==1.
- mesh_popin while in IDLE is ignored: no count, no state change.
- Latency:
  - req_pndng high in IDLE at cycle t → req_pop at t → mesh_pndng=1 and mesh_data valid from t+1.
  - popin at cycle c with another eligible requester → new packet on mesh_data at c+1, mesh_pndng stays 1.
- req_mask changes take effect on the next pick only; a held packet is never revoked.
- Combinational paths: mesh_popin→req_pop and req_pndng/req_mask→req_pop. Consumers must not combine them into a loop.
- req_pop is at most one-hot. It is never asserted for a requester with req_pndng=0 or req_mask=0.

Decomposition:
- Package mesh_arb_pkg holds:
  - state enum {IDLE, OFFER}.
  - function id_w(n) = max(1, $clog2(n)), used for ID_W.
- Sub-module rr_pick(num_req): combinational.
  - Inputs: eligible, ptr.
  - Outputs: any, winner index.
- The top level holds the FSM, hold register, pointer and counter.

Test Plan:
- Reset: drive reset=0 for 3 cycles with all req_pndng=1 → req_pop=0, mesh_pndng=0, pkt_cnt=0 throughout. Within 4 cycles of release, mesh_pndng=1 and grant_id=0.
- Single requester: req_pndng=4'b0100, data2=40'hAA_0000_0001, popin held 1 → req_pop=4'b0100 every cycle. mesh_data=40'hAA_0000_0001 from the next cycle; mesh_pndng continuous; pkt_cnt +1 per cycle.
- Fairness: all four pending and masked in, popin always 1 → grant_id sequence 0,1,2,3,0,… After 8 packets, pkt_cnt=8 with exactly 2 per requester.
- Backpressure: hold popin=0 for 10 cycles with packet from requester 1 offered → mesh_data constant, req_pop=0 all 10 cycles. Popin for 1 cycle → next requester (2) is loaded.
- Mask/boundary:
  - req_mask=4'b1001 with all pending → only ids 3,0,3,0. A popin in IDLE leaves pkt_cnt unchanged.
  - Reset asserted mid-OFFER → held packet dropped; after release, grant restarts from requester 0.
- Counter wrap: cnt_w=4, 17 accepted packets → pkt_cnt = 1.
